// File: rtl/demorgan_checker.sv
// Sweeps (A,B) through 00,01,10,11 into a De Morgan block and checks ~A, ~B and the combined term.
// Define DEMORGAN_OR_MODE_EN to check comb_in against ~A|~B instead of ~A&~B.
module demorgan_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       na_in,
    input  logic       nb_in,
    input  logic       comb_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [1:0] first_fail
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [3:0] SETTLE_W = SETTLE_CYCLES[3:0];
    localparam logic [7:0] PASSES_W = PASSES[7:0];

    logic [2:0] state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] pass_cnt_q, pass_cnt_d;
    logic [3:0] settle_q, settle_d;
    logic       a_q, a_d, b_q, b_d;
    logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [7:0] err_q, err_d;
    logic [1:0] ff_q, ff_d;
    logic       gold_comb, mism;

    always_comb begin
`ifdef DEMORGAN_OR_MODE_EN
        gold_comb = ~a_q | ~b_q;
`else
        gold_comb = ~a_q & ~b_q;
`endif
        // Case inequality so an X/Z response never counts as a match
        mism = (na_in !== ~a_q) || (nb_in !== ~b_q) || (comb_in !== gold_comb);
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        pass_cnt_d = pass_cnt_q;
        settle_d   = settle_q;
        a_d        = a_q;
        b_d        = b_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        ff_d       = ff_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d      = 8'd0;
                    ff_d       = 2'd0;
                    pass_d     = 1'b0;
                    vec_d      = 2'd0;
                    pass_cnt_d = 8'd0;
                    busy_d     = 1'b1;
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                a_d      = vec_q[1];
                b_d      = vec_q[0];
                settle_d = SETTLE_W;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                // Counter reaches 0 on this edge: SETTLE lasts exactly SETTLE_CYCLES cycles
                settle_d = settle_q - 4'd1;
                if (settle_q == 4'd1) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (mism) begin
                    if (err_q == 8'd0) ff_d = {a_q, b_q};
                    if (err_q != 8'd255) err_d = err_q + 8'd1;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = S_DRIVE;
                end else begin
                    vec_d      = 2'd0;
                    pass_cnt_d = pass_cnt_q + 8'd1;
                    if (pass_cnt_q + 8'd1 == PASSES_W) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_q == 8'd0);
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_DRIVE;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            vec_q      <= 2'd0;
            pass_cnt_q <= 8'd0;
            settle_q   <= 4'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= 8'd0;
            ff_q       <= 2'd0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            pass_cnt_q <= pass_cnt_d;
            settle_q   <= settle_d;
            a_q        <= a_d;
            b_q        <= b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            ff_q       <= ff_d;
        end
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
endmodule

// File: tb/tb_demorgan_checker.sv
// Scoreboard bench for demorgan_checker: behavioural De Morgan block models with planted faults.
module tb_demorgan_checker;
    localparam int S     = 2;
    localparam int P_SAT = 70;

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [1:0] ff;
        int         cyc;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, start_s = 1'b0;
    logic [1:0] mode = 2'd0;
    logic a_out, b_out, na_in, nb_in, comb_in, busy, done, pass;
    logic [7:0] err_count;
    logic [1:0] first_fail;
    logic sa, sb, sna, snb, scomb, s_busy, s_done, s_pass;
    logic [7:0] s_err;
    logic [1:0] s_ff;

    int n_tests = 0, n_fail = 0, cyc = 0, dn_cnt = 0, sdn_cnt = 0, accepted = 0;
    exp_t q_dut[$], q_sat[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model modes: 0 correct AND-form, 1 comb stuck at 0, 2 nb_in = B, 3 OR-form
    function automatic logic [2:0] resp(input logic [1:0] m, input logic a, input logic b);
        logic n_b, c;
        n_b = (m == 2'd2) ? b : ~b;
        c   = (m == 2'd1) ? 1'b0 : (m == 2'd3) ? (~a | ~b) : (~a & ~b);
        return {~a, n_b, c};
    endfunction

    function automatic exp_t expect_run(input logic [1:0] m, input int passes, input int c0);
        exp_t e;
        logic a, b, gc;
        logic [2:0] r;
        e.err = 8'd0;
        e.ff  = 2'd0;
        for (int p = 0; p < passes; p++)
            for (int v = 0; v < 4; v++) begin
                a = v[1];
                b = v[0];
`ifdef DEMORGAN_OR_MODE_EN
                gc = ~a | ~b;
`else
                gc = ~a & ~b;
`endif
                r = resp(m, a, b);
                if (r != {~a, ~b, gc}) begin
                    if (e.err == 8'd0) e.ff = {a, b};
                    if (e.err != 8'd255) e.err = e.err + 8'd1;
                end
            end
        e.pass = (e.err == 8'd0);
        e.cyc  = c0 + 4 * passes * (S + 3) + 1;
        return e;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    assign {na_in, nb_in, comb_in} = resp(mode, a_out, b_out);
    assign {sna, snb, scomb}       = resp(2'd2, sa, sb);

    demorgan_checker #(.SETTLE_CYCLES(S), .PASSES(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .a_out(a_out), .b_out(b_out),
        .na_in(na_in), .nb_in(nb_in), .comb_in(comb_in), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_fail(first_fail));

    demorgan_checker #(.SETTLE_CYCLES(S), .PASSES(P_SAT)) u_sat (
        .clk(clk), .reset(reset), .start(start_s), .a_out(sa), .b_out(sb),
        .na_in(sna), .nb_in(snb), .comb_in(scomb), .busy(s_busy), .done(s_done),
        .pass(s_pass), .err_count(s_err), .first_fail(s_ff));

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            dn_cnt++;
            if (q_dut.size() == 0) chk("dut_unexpected_done", 1, 0);
            else begin
                e = q_dut.pop_front();
                chk("dut_pass", pass, e.pass);
                chk("dut_err_count", err_count, e.err);
                chk("dut_first_fail", first_fail, e.ff);
                chk("dut_done_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && s_done) begin
            sdn_cnt++;
            if (q_sat.size() == 0) chk("sat_unexpected_done", 1, 0);
            else begin
                e = q_sat.pop_front();
                chk("sat_pass", s_pass, e.pass);
                chk("sat_err_count", s_err, e.err);
                chk("sat_first_fail", s_ff, e.ff);
                chk("sat_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_dut(input logic [1:0] m, input bit extra, input bit coincide);
        bit got;
        mode = m;
        q_dut.push_back(expect_run(m, 1, cyc));
        accepted++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (extra)
            repeat (2) begin
                repeat (3) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                if (coincide) start = 1'b1;
            end
        end
        if (!got) chk("dut_done_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_low_after_done", busy, 0);
        repeat (30) @(negedge clk);
        chk("busy_stays_idle", busy, 0);
        chk("done_count", dn_cnt, accepted);
    endtask

    initial begin
        bit got;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {a_out, b_out, busy, done, pass, err_count, first_fail}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_dut(2'd0, 1'b0, 1'b0);
        run_dut(2'd1, 1'b1, 1'b0);
        run_dut(2'd2, 1'b0, 1'b1);
        run_dut(2'd3, 1'b0, 1'b0);

        // Abort mid-run while vector 10 is settling
        mode  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (a_out && !b_out) got = 1'b1;
        end
        chk("reach_vec10", got, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_reset_outputs", {a_out, b_out, busy, done, pass, err_count, first_fail}, 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", dn_cnt, accepted);
        run_dut(2'd0, 1'b0, 1'b0);

        // Saturation: PASSES=70 with nb inverted gives 280 raw mismatches
        q_sat.push_back(expect_run(2'd2, P_SAT, cyc));
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        chk("sat_busy_after_start", s_busy, 1);
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (s_done) got = 1'b1;
        end
        if (!got) chk("sat_done_timeout", 0, 1);
        repeat (5) @(negedge clk);
        chk("sat_done_count", sdn_cnt, 1);
        chk("sat_err_held", s_err, 255);
        chk("dut_queue_drained", q_dut.size(), 0);
        chk("sat_queue_drained", q_sat.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/demorgan_checker.md
Name: demorgan_checker

Overview:
- Hardware self-checking counterpart to the De Morgan truth-table stimulus flow.
- Sweeps (A,B) through all four combinations and drives them to the gate-level De Morgan block.
- Samples the returned nA, nB and combined term after a settle interval, compares each sample against golden values, and reports a mismatch count, the first failing vector and a pass/done status.
- Sits beside the De Morgan block in FPGA/bring-up builds where no simulator $display is available.

Parameters:
- SETTLE_CYCLES, 2, clock cycles between driving a vector and sampling the response; legal range 1..15.
- PASSES, 1, number of complete 4-vector sweeps per start; legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a run when idle
- a_out  output  1  A stimulus to the block under check
- b_out  output  1  B stimulus to the block under check
- na_in  input  1  returned ~A
- nb_in  input  1  returned ~B
- comb_in  input  1  returned combined term, ~A&~B by default (see Optional Feature)
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the run completes
- pass  output  1  valid from the done pulse onward; 1 means zero mismatches; held until the next accepted start
- err_count  output  8  saturating mismatch count for the current run
- first_fail  output  2  {A,B} of the first mismatching vector; 0 if none

Behaviour:
- Reset: every output is 0 (a_out, b_out, busy, done, pass, err_count, first_fail); FSM enters IDLE; counters are cleared. Reset has priority over all other events, including mid-run; an aborted run produces no done pulse.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, NEXT, FINISH.
- IDLE: a start pulse clears err_count, first_fail and pass, sets vec=0 and pass_cnt=0, and moves to DRIVE. A start seen outside IDLE is ignored.
- DRIVE: {a_out,b_out} <= vec; the settle counter is loaded with SETTLE_CYCLES; next state is SETTLE.
- SETTLE: the counter decrements each cycle. On reaching 0, go to CHECK. Inputs are therefore sampled exactly SETTLE_CYCLES+1 cycles after a_out/b_out change.
- CHECK: golden values are na=~a_out, nb=~b_out, comb=~a_out&~b_out. Any bit differing counts as one mismatch per vector.
  - err_count increments by 1 and saturates at 255.
  - first_fail is captured only on the first mismatch of the run.
- NEXT:
  - If vec≠3: vec increments, go to DRIVE.
  - If vec=3: vec wraps to 0 and pass_cnt increments. If pass_cnt reaches PASSES, go to FINISH; otherwise go to DRIVE.
- FINISH: done=1 for one cycle; pass=(err_count==0); busy=0; return to IDLE. a_out/b_out hold the last vector, {1,1}.
- Vector order: 00, 01, 10, 11, matching the truth-table convention.
- Timing: start accepted in cycle 0 means busy is high from cycle 1, and done fires after 4·PASSES·(SETTLE_CYCLES+3) cycles plus 1 for FINISH.
- A start arriving in the same cycle as the done pulse is ignored, because the FSM is in FINISH, not IDLE.
- X/Z on the inputs is treated as a mismatch. Implementations use the !== semantics equivalent in synthesis; X is never counted as a match.

Optional Feature:
- Macro: DEMORGAN_OR_MODE_EN.
- Defined: comb_in is checked against ~a_out|~b_out, the OR-form combined term, for use with the OR-combination variant of the De Morgan block.
- Undefined: comb_in is checked against ~a_out&~b_out.
- All other behaviour and timing are identical in both cases.

Test Plan:
- Correct AND-form model, SETTLE_CYCLES=2, PASSES=1, start pulse -> done after 4·5+1=21 cycles; pass=1, err_count=0, first_fail=0.
- Model with comb_in stuck at 0 -> mismatch only at vector 00; err_count=1, first_fail=2'b00, pass=0.
- Model with nb_in inverted (nb_in=B) -> mismatches at all 4 vectors; err_count=4, first_fail=2'b00; with PASSES=70, err_count=255 (saturated, not 280).
- reset asserted in SETTLE of vector 10 -> next cycle all outputs 0, state IDLE, no done pulse; a fresh start then completes normally with pass=1.
- Extra start pulses while busy, plus one coincident with done -> ignored; exactly one done per accepted start.
- With DEMORGAN_OR_MODE_EN defined and an OR-form model -> pass=1. With DEMORGAN_OR_MODE_EN defined and an AND-form model -> err_count=2 (vectors 01 and 10), first_fail=2'b01.
